// File: rtl/trdb_filter_ctrl.sv
// Trace qualification controller: session FSM (OFF/WAIT/ON/DRAIN) plus per-instruction
// address-range and privilege filtering, with registered outputs toward the trace encoder.
module trdb_filter_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned N_RANGES     = 2,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     trace_enable_i,
  input  logic                     trigger_trace_on_i,
  input  logic                     trigger_trace_off_i,
  input  logic                     apply_filters_i,
  input  logic                     trace_selected_priv_i,
  input  logic [1:0]               which_priv_i,
  input  logic [1:0]               priv_lvl_i,
  input  logic                     iretire_i,
  input  logic [XLEN-1:0]          iaddr_i,
  input  logic [N_RANGES-1:0]      range_en_i,
  input  logic [N_RANGES-1:0]      range_mode_i,
  input  logic [N_RANGES*XLEN-1:0] range_lower_i,
  input  logic [N_RANGES*XLEN-1:0] range_upper_i,
  output logic                     nc_trace_qualified_o,
  output logic                     trace_range_match_o,
  output logic                     trace_priv_match_o,
  output logic                     trace_active_o,
  output logic                     trace_req_deactivate_o
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_ON, ST_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               qual_q, qual_d;
  logic               rmatch_q, rmatch_d;
  logic               pmatch_q, pmatch_d;
  logic               deact_q, deact_d;

  logic [N_RANGES-1:0] win_en, win_hit, start_hit, stop_hit;
  logic                range_ok, priv_ok, has_ss, start_any, stop_any, go_on;

  // Range comparators (all unsigned); an empty window (lower >= upper) can never hit.
  always_comb begin
    win_hit   = '0;
    start_hit = '0;
    stop_hit  = '0;
    for (int r = 0; r < N_RANGES; r++) begin
      win_hit[r]   = range_en_i[r] & ~range_mode_i[r]
                   & (range_lower_i[r*XLEN +: XLEN] <= iaddr_i)
                   & (iaddr_i < range_upper_i[r*XLEN +: XLEN]);
      start_hit[r] = range_en_i[r] & range_mode_i[r] & iretire_i
                   & (iaddr_i == range_lower_i[r*XLEN +: XLEN]);
      stop_hit[r]  = range_en_i[r] & range_mode_i[r] & iretire_i
                   & (iaddr_i == range_upper_i[r*XLEN +: XLEN]);
    end
  end

  assign win_en    = range_en_i & ~range_mode_i;
  assign range_ok  = ~(|win_en) | (|win_hit);
  assign priv_ok   = ~trace_selected_priv_i | (priv_lvl_i == which_priv_i);
  assign has_ss    = apply_filters_i & (|(range_en_i & range_mode_i));
  assign start_any = has_ss & (|start_hit);
  assign stop_any  = has_ss & (|stop_hit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deact_d = 1'b0;
    go_on   = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (trace_enable_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (trigger_trace_on_i | start_any | ~has_ss) begin
          state_d = ST_ON;
          go_on   = 1'b1;
        end
      end
      ST_ON: begin
        // A stop cause wins over a simultaneous start cause.
        if (trigger_trace_off_i | stop_any) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_OFF;
          deact_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
    // Dropping the global enable aborts the session silently from any state.
    if (!trace_enable_i) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      deact_d = 1'b0;
      go_on   = 1'b0;
    end
  end

  assign qual_d   = iretire_i & trace_enable_i
                  & ((state_q == ST_ON) | (state_q == ST_DRAIN) | go_on)
                  & (~apply_filters_i | (range_ok & priv_ok));
  assign rmatch_d = iretire_i & range_ok;
  assign pmatch_d = iretire_i & priv_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      qual_q   <= 1'b0;
      rmatch_q <= 1'b0;
      pmatch_q <= 1'b0;
      deact_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      qual_q   <= qual_d;
      rmatch_q <= rmatch_d;
      pmatch_q <= pmatch_d;
      deact_q  <= deact_d;
    end
  end

  assign nc_trace_qualified_o   = qual_q;
  assign trace_range_match_o    = rmatch_q;
  assign trace_priv_match_o     = pmatch_q;
  assign trace_active_o         = (state_q == ST_ON) | (state_q == ST_DRAIN);
  assign trace_req_deactivate_o = deact_q;

endmodule

// File: tb/tb_trdb_filter_ctrl.sv
// Bench for trdb_filter_ctrl: vector table plus hand sequences, expected outputs queued per cycle.
module tb_trdb_filter_ctrl;

  localparam int XLEN = 32;
  localparam int NR   = 2;

  logic            clk = 1'b0;
  logic            rst_i, en_i, ton_i, toff_i, apply_i, selp_i, iret_i;
  logic [1:0]      which_i, lvl_i;
  logic [XLEN-1:0] iaddr_i;
  logic [NR-1:0]   ren_i, rmode_i;
  logic [NR*XLEN-1:0] rlo_i, rhi_i;
  logic            qual_o, rm_o, pm_o, act_o, deact_o;

  trdb_filter_ctrl #(.XLEN(XLEN), .N_RANGES(NR), .DRAIN_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .trace_enable_i(en_i),
    .trigger_trace_on_i(ton_i), .trigger_trace_off_i(toff_i),
    .apply_filters_i(apply_i), .trace_selected_priv_i(selp_i),
    .which_priv_i(which_i), .priv_lvl_i(lvl_i), .iretire_i(iret_i), .iaddr_i(iaddr_i),
    .range_en_i(ren_i), .range_mode_i(rmode_i), .range_lower_i(rlo_i), .range_upper_i(rhi_i),
    .nc_trace_qualified_o(qual_o), .trace_range_match_o(rm_o), .trace_priv_match_o(pm_o),
    .trace_active_o(act_o), .trace_req_deactivate_o(deact_o)
  );

  always #5 clk = ~clk;

  // ctl = {rst, en, trig_on, trig_off, apply, sel_priv}; exp = {qual, range_m, priv_m, active, deact}
  typedef struct {
    logic [5:0]  ctl;
    logic [1:0]  which;
    logic [1:0]  lvl;
    logic        iret;
    logic [31:0] addr;
    logic [4:0]  exp;
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] sb[$];
  string      tag_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [4:0] e;
    string      t;
    {rst_i, en_i, ton_i, toff_i, apply_i, selp_i} = v.ctl;
    which_i = v.which;
    lvl_i   = v.lvl;
    iret_i  = v.iret;
    iaddr_i = v.addr;
    sb.push_back(v.exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    t = tag_q.pop_front();
    chk({t, ".qualified"},   qual_o,  e[4]);
    chk({t, ".range_match"}, rm_o,    e[3]);
    chk({t, ".priv_match"},  pm_o,    e[2]);
    chk({t, ".active"},      act_o,   e[1]);
    chk({t, ".deactivate"},  deact_o, e[0]);
  endtask

  task automatic seq(input string name, input vec_t vs[$]);
    foreach (vs[i]) run_vec($sformatf("%s[%0d]", name, i), vs[i]);
  endtask

  initial begin
    vec_t vs[$];
    {rst_i, en_i, ton_i, toff_i, apply_i, selp_i, iret_i} = '0;
    which_i = '0; lvl_i = '0; iaddr_i = '0;
    // r0: window [0x1000,0x2000)
    ren_i = 2'b01; rmode_i = 2'b00;
    rlo_i = {32'h0, 32'h1000};
    rhi_i = {32'h0, 32'h2000};

    // Power-on reset
    for (int i = 0; i < 3; i++) tbl.push_back(vec_t'{6'b100000, 2'd0, 2'd0, 1'b0, 32'h0, 5'b00000});
    // No filters
    tbl.push_back(vec_t'{6'b010000, 2'd0, 2'd0, 1'b1, 32'h1800, 5'b01100});
    tbl.push_back(vec_t'{6'b010000, 2'd0, 2'd0, 1'b1, 32'h1800, 5'b11110});
    tbl.push_back(vec_t'{6'b010000, 2'd0, 2'd0, 1'b1, 32'h1800, 5'b11110});
    tbl.push_back(vec_t'{6'b000000, 2'd0, 2'd0, 1'b1, 32'h1800, 5'b01100});
    tbl.push_back(vec_t'{6'b000000, 2'd0, 2'd0, 1'b1, 32'h1800, 5'b01100});
    // Window filtering and privilege filter
    tbl.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b0, 32'h0,    5'b00000});
    tbl.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b0, 32'h0,    5'b00010});
    tbl.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b1, 32'h0FFC, 5'b00110});
    tbl.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b1, 32'h1000, 5'b11110});
    tbl.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b1, 32'h1FFC, 5'b11110});
    tbl.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b1, 32'h2000, 5'b00110});
    tbl.push_back(vec_t'{6'b010011, 2'd3, 2'd0, 1'b1, 32'h1000, 5'b01010});
    tbl.push_back(vec_t'{6'b010011, 2'd3, 2'd3, 1'b1, 32'h1000, 5'b11110});
    tbl.push_back(vec_t'{6'b010001, 2'd3, 2'd0, 1'b1, 32'h3000, 5'b10010});
    tbl.push_back(vec_t'{6'b000000, 2'd0, 2'd0, 1'b0, 32'h0,    5'b00000});
    for (int i = 0; i < tbl.size(); i++) run_vec($sformatf("tbl[%0d]", i), tbl[i]);

    // r1: start/stop 0x400 / 0x800
    ren_i = 2'b10; rmode_i = 2'b10;
    rlo_i = {32'h400, 32'h0};
    rhi_i = {32'h800, 32'h0};
    vs = '{};
    vs.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b0, 32'h0,   5'b00000});
    vs.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b1, 32'h300, 5'b01100});
    vs.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b1, 32'h400, 5'b11110});
    vs.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b1, 32'h500, 5'b11110});
    vs.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b1, 32'h800, 5'b11110});
    for (int i = 0; i < 3; i++) vs.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b0, 32'h0, 5'b00010});
    vs.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b0, 32'h0,   5'b00001});
    vs.push_back(vec_t'{6'b000010, 2'd0, 2'd0, 1'b0, 32'h0,   5'b00000});
    seq("startstop", vs);

    // trig_off with start hit in ON; trig_off and trig_on ignored in DRAIN
    vs = '{};
    vs.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b0, 32'h0,   5'b00000});
    vs.push_back(vec_t'{6'b011010, 2'd0, 2'd0, 1'b0, 32'h0,   5'b00010});
    vs.push_back(vec_t'{6'b010110, 2'd0, 2'd0, 1'b1, 32'h400, 5'b11110});
    vs.push_back(vec_t'{6'b010110, 2'd0, 2'd0, 1'b0, 32'h0,   5'b00010});
    vs.push_back(vec_t'{6'b011010, 2'd0, 2'd0, 1'b1, 32'h400, 5'b11110});
    vs.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b0, 32'h0,   5'b00010});
    vs.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b0, 32'h0,   5'b00001});
    vs.push_back(vec_t'{6'b000010, 2'd0, 2'd0, 1'b0, 32'h0,   5'b00000});
    seq("simul", vs);

    // start == stop address: WAIT goes ON, then ON goes DRAIN; enable drop gives no pulse
    rlo_i = {32'h600, 32'h0};
    rhi_i = {32'h600, 32'h0};
    vs = '{};
    vs.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b0, 32'h0,   5'b00000});
    vs.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b1, 32'h600, 5'b11110});
    vs.push_back(vec_t'{6'b010010, 2'd0, 2'd0, 1'b1, 32'h600, 5'b11110});
    vs.push_back(vec_t'{6'b000010, 2'd0, 2'd0, 1'b0, 32'h0,   5'b00000});
    seq("samept", vs);

    // Reset mid-ON: outputs clear, no pulse, FSM restarts from OFF
    ren_i = 2'b00;
    vs = '{};
    vs.push_back(vec_t'{6'b010000, 2'd0, 2'd0, 1'b1, 32'h0, 5'b01100});
    vs.push_back(vec_t'{6'b010000, 2'd0, 2'd0, 1'b1, 32'h0, 5'b11110});
    for (int i = 0; i < 3; i++) vs.push_back(vec_t'{6'b110000, 2'd0, 2'd0, 1'b1, 32'h0, 5'b00000});
    vs.push_back(vec_t'{6'b010000, 2'd0, 2'd0, 1'b1, 32'h0, 5'b01100});
    vs.push_back(vec_t'{6'b010000, 2'd0, 2'd0, 1'b1, 32'h0, 5'b11110});
    vs.push_back(vec_t'{6'b000000, 2'd0, 2'd0, 1'b0, 32'h0, 5'b00000});
    seq("rst", vs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
